// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core.
// Tracks register-use info for the instructions in X, M and W, and drives
// the fetch/decode load enables, the NOP-insertion controls and the ALU
// operand forwarding selects. It also counts stall and redirect cycles.
module hazard_ctrl #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_d,
  input  logic              br_taken_x,
  output logic              pc_load,
  output logic              id_load,
  output logic              id_flush,
  output logic              ie_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CWIDTH-1:0] stall_cnt,
  output logic [CWIDTH-1:0] flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Events originate in the DWIDTH domain, so the saturation ceiling never
  // exceeds what that domain can represent (identical to CWIDTH by default).
  localparam int          CNT_W   = (CWIDTH < DWIDTH) ? CWIDTH : DWIDTH;
  localparam logic [CWIDTH-1:0] CNT_MAX = CWIDTH'((64'd1 << CNT_W) - 64'd1);

  // Full register-use record for the instruction in X (needed for forwarding
  // and load-use detection).
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
  } x_info_t;

  // M only matters as a producer (and whether that producer is a load).
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } m_info_t;

  // W only matters as a producer; its data is always ready to forward.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
  } w_info_t;

  x_info_t dec;
  x_info_t s_x;
  m_info_t s_m;
  w_info_t s_w;
  logic    luh;
  logic    stall_evt;
  logic    unused_inst_bits;

  // funct3/funct7 do not affect register usage.
  assign unused_inst_bits = ^{inst_d[31:25], inst_d[14:12]};

  // Decode register usage of the instruction sitting in the ID register.
  always_comb begin
    dec      = '0;
    dec.rd   = inst_d[11:7];
    dec.rs1  = inst_d[19:15];
    dec.rs2  = inst_d[24:20];
    case (inst_d[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: dec.wr = 1'b1;
      OP_JALR: begin
        dec.wr   = 1'b1;
        dec.use1 = 1'b1;
      end
      OP_BRANCH: begin
        dec.use1 = 1'b1;
        dec.use2 = 1'b1;
      end
      OP_LOAD: begin
        dec.wr   = 1'b1;
        dec.ld   = 1'b1;
        dec.use1 = 1'b1;
      end
      OP_STORE: begin
        dec.use1 = 1'b1;
        dec.use2 = 1'b1;
      end
      OP_IMM: begin
        dec.wr   = 1'b1;
        dec.use1 = 1'b1;
      end
      OP_REG: begin
        dec.wr   = 1'b1;
        dec.use1 = 1'b1;
        dec.use2 = 1'b1;
      end
      default: dec.wr = 1'b0;
    endcase
    // x0 is hardwired, so a write to it never produces a forwardable value.
    if (dec.rd == 5'd0) dec.wr = 1'b0;
  end

  // Load in X whose result the instruction in D needs: one bubble required.
  always_comb begin
    luh = s_x.ld && s_x.wr &&
          ((dec.use1 && (dec.rs1 == s_x.rd)) ||
           (dec.use2 && (dec.rs2 == s_x.rd)));
  end

  // Redirect beats stall: a consumer behind a taken redirect is wrong-path.
  always_comb begin
    pc_load   = 1'b1;
    id_load   = 1'b1;
    id_flush  = 1'b0;
    ie_flush  = 1'b0;
    stall_evt = 1'b0;
    if (br_taken_x) begin
      id_flush = 1'b1;
      ie_flush = 1'b1;
    end else if (luh) begin
      pc_load   = 1'b0;
      id_load   = 1'b0;
      ie_flush  = 1'b1;
      stall_evt = 1'b1;
    end
  end

  // Operand forwarding into X; the youngest producer (M) wins over W, and a
  // load in M never forwards because its data is not ready yet.
  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (s_x.use1 && s_m.wr && !s_m.ld && (s_m.rd == s_x.rs1))
      fwd_a_sel = 2'd1;
    else if (s_x.use1 && s_w.wr && (s_w.rd == s_x.rs1))
      fwd_a_sel = 2'd2;
    if (s_x.use2 && s_m.wr && !s_m.ld && (s_m.rd == s_x.rs2))
      fwd_b_sel = 2'd1;
    else if (s_x.use2 && s_w.wr && (s_w.rd == s_x.rs2))
      fwd_b_sel = 2'd2;
  end

  // Shadow pipeline advances every cycle, mirroring the IE register's bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_x <= '0;
      s_m <= '0;
      s_w <= '0;
    end else begin
      s_x    <= ie_flush ? '0 : dec;
      s_m.rd <= s_x.rd;
      s_m.wr <= s_x.wr;
      s_m.ld <= s_x.ld;
      s_w.rd <= s_m.rd;
      s_w.wr <= s_m.wr;
    end
  end

  // Saturating performance counters for stall and redirect cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (br_taken_x && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl. The driver pushes a
// hand-computed expectation per cycle; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int CW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [31:0]   inst_d;
  logic          br_taken_x;
  logic          pc_load;
  logic          id_load;
  logic          id_flush;
  logic          ie_flush;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl #(.DWIDTH(32), .CWIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_d     (inst_d),
    .br_taken_x (br_taken_x),
    .pc_load    (pc_load),
    .id_load    (id_load),
    .id_flush   (id_flush),
    .ie_flush   (ie_flush),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] op_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] op_addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] op_lw(logic [4:0] rd, logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  // kind: 0 RUN, 1 STALL, 2 REDIRECT
  task automatic applyStimulus(input string name, input logic [31:0] inst,
                               input logic br, input logic rst_v, input int kind,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input int sc, input int fc);
    exp_t e;
    logic [3:0] ctl;
    @(posedge clk);
    #1;
    rst        = rst_v;
    inst_d     = inst;
    br_taken_x = br;
    case (kind)
      1:       ctl = 4'b0001;
      2:       ctl = 4'b1111;
      default: ctl = 4'b1100;
    endcase
    e.name = name;
    e.exp  = {ctl, fa, fb, CW'(sc), CW'(fc)};
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [15:0] act;
    act = {pc_load, id_load, id_flush, ie_flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: got {pl,il,idf,ief,fa,fb,sc,fc}=%b_%b_%b_%b_%0d_%0d_%0d_%0d expected %b_%b_%b_%b_%0d_%0d_%0d_%0d",
               e.name, act[15], act[14], act[13], act[12], act[11:10], act[9:8], act[7:4], act[3:0],
               e.exp[15], e.exp[14], e.exp[13], e.exp[12], e.exp[11:10], e.exp[9:8], e.exp[7:4], e.exp[3:0]);
    end
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    int sc_a;
    int sc_c;
    rst        = 1'b1;
    inst_d     = NOP;
    br_taken_x = 1'b0;

    applyStimulus("reset",        NOP, 0, 1, 0, 0, 0, 0, 0);

    // ALU chain, back-to-back / one gap / two gaps
    applyStimulus("alu0_prod",    op_add(5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu0_cons",    op_add(5'd4, 5'd1, 5'd5), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu0_fwd_m",   NOP,                      0, 0, 0, 1, 0, 0, 0);
    applyStimulus("alu1_prod",    op_add(5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu1_mid",     op_addi(5'd9, 5'd0, 12'd1), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu1_cons",    op_add(5'd4, 5'd1, 5'd5), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu1_fwd_w",   NOP,                      0, 0, 0, 2, 0, 0, 0);
    applyStimulus("alu2_prod",    op_add(5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu2_mid1",    op_addi(5'd9, 5'd0, 12'd1), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu2_mid2",    op_addi(5'd10, 5'd0, 12'd2), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu2_cons",    op_add(5'd4, 5'd1, 5'd5), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("alu2_nofwd",   NOP,                      0, 0, 0, 0, 0, 0, 0);

    // Load-use: one stall, then forward from W on both operands
    applyStimulus("lu_load",      op_lw(5'd6, 5'd0),        0, 0, 0, 0, 0, 0, 0);
    applyStimulus("lu_stall",     op_add(5'd7, 5'd6, 5'd6), 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("lu_release",   op_add(5'd7, 5'd6, 5'd6), 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("lu_fwd_w",     NOP,                      0, 0, 0, 2, 2, 1, 0);

    // Taken branch: the flushed producer must not forward afterwards
    applyStimulus("br_redirect",  op_add(5'd1, 5'd2, 5'd3), 1, 0, 2, 0, 0, 1, 0);
    applyStimulus("br_after",     op_add(5'd4, 5'd1, 5'd5), 0, 0, 0, 0, 0, 1, 1);
    applyStimulus("br_no_fwd",    NOP,                      0, 0, 0, 0, 0, 1, 1);

    // Redirect concurrent with a load-use hazard
    applyStimulus("cc_load",      op_lw(5'd6, 5'd0),        0, 0, 0, 0, 0, 1, 1);
    applyStimulus("cc_redirect",  op_add(5'd7, 5'd6, 5'd6), 1, 0, 2, 0, 0, 1, 1);
    applyStimulus("cc_after",     NOP,                      0, 0, 0, 0, 0, 1, 2);

    // Writes to x0 never forward or stall
    applyStimulus("x0_write",     op_addi(5'd0, 5'd0, 12'd5), 0, 0, 0, 0, 0, 1, 2);
    applyStimulus("x0_read",      op_add(5'd8, 5'd0, 5'd0), 0, 0, 0, 0, 0, 1, 2);
    applyStimulus("x0_in_x",      NOP,                      0, 0, 0, 0, 0, 1, 2);
    applyStimulus("x0_drain",     NOP,                      0, 0, 0, 0, 0, 1, 2);

    // Back-to-back dependent loads: each consumer stalls exactly once
    applyStimulus("bb_load1",     op_lw(5'd6, 5'd0),        0, 0, 0, 0, 0, 1, 2);
    applyStimulus("bb_stall1",    op_lw(5'd11, 5'd6),       0, 0, 1, 0, 0, 1, 2);
    applyStimulus("bb_run1",      op_lw(5'd11, 5'd6),       0, 0, 0, 0, 0, 2, 2);
    applyStimulus("bb_stall2",    op_add(5'd12, 5'd11, 5'd0), 0, 0, 1, 2, 0, 2, 2);
    applyStimulus("bb_run2",      op_add(5'd12, 5'd11, 5'd0), 0, 0, 0, 0, 0, 3, 2);
    applyStimulus("bb_fwd_w",     NOP,                      0, 0, 0, 2, 0, 3, 2);

    // Saturation: 20 more stall cycles push stall_cnt past 15
    for (int i = 0; i < 20; i++) begin
      sc_a = (3 + i > 15) ? 15 : 3 + i;
      sc_c = (4 + i > 15) ? 15 : 4 + i;
      applyStimulus($sformatf("sat%0d_load", i), op_lw(5'd6, 5'd0), 0, 0, 0,
                    (i == 0) ? 2'd0 : 2'd2, (i == 0) ? 2'd0 : 2'd2, sc_a, 2);
      applyStimulus($sformatf("sat%0d_stall", i), op_add(5'd7, 5'd6, 5'd6), 0, 0, 1, 0, 0, sc_a, 2);
      applyStimulus($sformatf("sat%0d_run", i), op_add(5'd7, 5'd6, 5'd6), 0, 0, 0, 0, 0, sc_c, 2);
    end

    // Async reset in the middle of a load-use stall
    applyStimulus("rs_load",      op_lw(5'd6, 5'd0),        0, 0, 0, 2, 2, 15, 2);
    applyStimulus("rs_assert",    op_add(5'd7, 5'd6, 5'd6), 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("rs_hold",      op_add(5'd7, 5'd6, 5'd6), 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("rs_release",   op_add(5'd7, 5'd6, 5'd6), 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rs_clean",     NOP,                      0, 0, 0, 0, 0, 0, 0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
